// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_pkg                                                      |
// | Description : Shared AES types and constants for the iterative             |
// |               InvSubBytes engine: state/byte types, the engine FSM         |
// |               state encoding and the number of bytes in a state.           |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } inv_sb_state_e;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/inv_sbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inv_sbox                                                     |
// | Description : Combinational AES inverse S-box (InvS). Port shape is the    |
// |               same as the forward sbox so the two can sit side by side.    |
// | Ports       : x     in  4  low nibble of the input byte                    |
// |               y     in  4  high nibble of the input byte                   |
// |               sbout out 8  InvS({y,x})                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module inv_sbox (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] sbout
);

  // Entry 0 is the most significant byte, so entry i lives at bit
  // 8*(255-i), which is simply {~i, 3'b000}.
  localparam logic [2047:0] c_inv_table = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [7:0]  w_idx;
  logic [10:0] w_bitpos;

  assign w_idx    = {y, x};
  assign w_bitpos = {~w_idx, 3'b000};
  assign sbout    = c_inv_table[w_bitpos +: 8];

endmodule : inv_sbox
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sbox                                                         |
// | Description : Combinational AES forward S-box. Only compiled when the      |
// |               AES_SBOX_FWD_EN macro is defined, so the default build of    |
// |               the InvSubBytes engine carries no forward table.             |
// | Ports       : x     in  4  low nibble of the input byte                    |
// |               y     in  4  high nibble of the input byte                   |
// |               sbout out 8  S({y,x})                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`ifdef AES_SBOX_FWD_EN
module sbox (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] sbout
);

  localparam logic [2047:0] c_fwd_table = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0]  w_idx;
  logic [10:0] w_bitpos;

  assign w_idx    = {y, x};
  assign w_bitpos = {~w_idx, 3'b000};
  assign sbout    = c_fwd_table[w_bitpos +: 8];

endmodule : sbox
`endif
`default_nettype wire

// File: rtl/inv_sub_byte_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inv_sub_byte_iter                                            |
// | Description : Iterative AES InvSubBytes engine. A 128-bit state is         |
// |               accepted on a valid/ready handshake and substituted          |
// |               BYTES_PER_CYCLE bytes per clock through shared inv_sbox      |
// |               lanes; the result is offered on a valid/ready output.        |
// |               Macro AES_SBOX_FWD_EN adds mode_i and a forward sbox per     |
// |               lane (mode latched at acceptance: 0 inverse, 1 forward).     |
// | Parameters  : BYTES_PER_CYCLE  bytes per BUSY cycle (1, 2, 4, 8 or 16)     |
// | Ports       : clk_i    in  1    clock                                      |
// |               reset_i  in  1    asynchronous active-high reset             |
// |               valid_i  in  1    data_i valid                               |
// |               ready_o  out 1    block accepts data_i this cycle            |
// |               data_i   in  128  input state, byte k = data_i[8k+7:8k]      |
// |               valid_o  out 1    data_o holds a completed result            |
// |               ready_i  in  1    downstream consumes data_o this cycle      |
// |               data_o   out 128  byte k = InvS(input byte k)                |
// |               mode_i   in  1    (AES_SBOX_FWD_EN only) 0 inv, 1 fwd        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module inv_sub_byte_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] data_o
`ifdef AES_SBOX_FWD_EN
  ,
  input  logic         mode_i
`endif
);

  localparam int c_num_chunks = AES_STATE_BYTES / BYTES_PER_CYCLE;
  localparam int c_chunk_w    = 8 * BYTES_PER_CYCLE;
  localparam int c_cnt_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
  localparam logic [c_cnt_w-1:0] c_last_chunk = c_cnt_w'(c_num_chunks - 1);

  // The state is viewed as an array of chunks so the counter indexes a
  // whole chunk directly (its width is exactly log2 of the chunk count).
  typedef logic [c_num_chunks-1:0][c_chunk_w-1:0] chunk_arr_t;

  inv_sb_state_e        r_st;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_valid;
  chunk_arr_t           r_state;
  chunk_arr_t           r_result;
  chunk_arr_t           w_result_next;
  logic [c_chunk_w-1:0] w_chunk_in;
  logic [c_chunk_w-1:0] w_chunk_out;
`ifdef AES_SBOX_FWD_EN
  logic                 r_mode;
`endif

  // ---------------------------------------------------------------------------
  // Chunk select / write-back. With a single chunk the counter is a dummy bit
  // and must not be used as an index.
  // ---------------------------------------------------------------------------
  if (c_num_chunks == 1) begin : g_single_chunk
    assign w_chunk_in = r_state[0];
    always_comb begin
      w_result_next    = r_result;
      w_result_next[0] = w_chunk_out;
    end
  end else begin : g_multi_chunk
    assign w_chunk_in = r_state[r_cnt];
    always_comb begin
      w_result_next        = r_result;
      w_result_next[r_cnt] = w_chunk_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Substitution lanes
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_lane
    aes_byte_t w_lane_in;
    aes_byte_t w_lane_inv;

    assign w_lane_in = w_chunk_in[8*i +: 8];

    inv_sbox u_inv_sbox (
      .x     (w_lane_in[3:0]),
      .y     (w_lane_in[7:4]),
      .sbout (w_lane_inv)
    );

`ifdef AES_SBOX_FWD_EN
    aes_byte_t w_lane_fwd;

    sbox u_sbox (
      .x     (w_lane_in[3:0]),
      .y     (w_lane_in[7:4]),
      .sbout (w_lane_fwd)
    );

    assign w_chunk_out[8*i +: 8] = r_mode ? w_lane_fwd : w_lane_inv;
`else
    assign w_chunk_out[8*i +: 8] = w_lane_inv;
`endif
  end

  // ---------------------------------------------------------------------------
  // Control FSM. valid_o is registered; it is only ever set on the edge that
  // writes the last chunk, so a reset anywhere before that leaves it low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_st     <= IDLE;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_state  <= '0;
      r_result <= '0;
`ifdef AES_SBOX_FWD_EN
      r_mode   <= 1'b0;
`endif
    end else begin
      case (r_st)
        IDLE: begin
          if (valid_i) begin
            r_state <= data_i;
`ifdef AES_SBOX_FWD_EN
            r_mode  <= mode_i;
`endif
            r_cnt   <= '0;
            r_st    <= BUSY;
          end
        end

        BUSY: begin
          r_result <= w_result_next;
          if (r_cnt == c_last_chunk) begin
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_st    <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DONE: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            // ready_o follows ready_i here, so a concurrent valid_i is a
            // legal handshake and starts the next state without an idle gap.
            if (valid_i) begin
              r_state <= data_i;
`ifdef AES_SBOX_FWD_EN
              r_mode  <= mode_i;
`endif
              r_cnt   <= '0;
              r_st    <= BUSY;
            end else begin
              r_st <= IDLE;
            end
          end
        end

        default: begin
          r_st    <= IDLE;
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = (r_st == IDLE) || ((r_st == DONE) && ready_i);
  assign valid_o = r_valid;
  assign data_o  = r_result;

endmodule : inv_sub_byte_iter
`default_nettype wire
